lstm_gate_sched: RTL and testbench
==================================

Name: lstm_gate_sched

Overview:
- Sequencer that time-multiplexes one dot_prod matrix-vector unit and its weightRAM across the NGATES LSTM gates (i, f, o, c), one gate after another.
- Per gate: selects the weight bank and restarts dot_prod through its reset. It then waits for the dataReady rising edge and captures outputVec into a per-gate result bank.
- Sits between the layer controller (start/done) and the dot_prod/weightRAM pair.

Parameters:
- NROW, 16, rows per gate matrix / elements in outputVec
- NCOL, 8, columns (passed through for width derivation only)
- QN, 6, integer bits of the fixed-point format
- QM, 11, fractional bits of the fixed-point format
- NGATES, 4, number of gates sequenced per run (at least 1)
- CLR_CYCLES, 2, cycles dpReset is held high before each gate run (at least 1)
- TIMEOUT, 256, maximum RUN cycles allowed without a dataReady edge
- Derived: BITWIDTH = QN+QM+1; MEMORY_BITWIDTH = BITWIDTH*NROW; GSEL_W = max(1, clog2(NGATES))

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle run request; sampled only in IDLE
- abort  in  1  cancels the run in progress
- dpDataReady  in  1  dataReady from dot_prod
- dpOutputVec  in  MEMORY_BITWIDTH  outputVec from dot_prod
- dpReset  out  1  reset to dot_prod and weightRAM; high restarts the column sweep
- gateSel  out  GSEL_W  weight-bank select for the gate currently being run
- busy  out  1  high from start acceptance until DONE/abort/error
- done  out  1  one-cycle pulse after the last gate has been captured
- error  out  1  sticky watchdog flag; cleared on the next accepted start
- resValid  out  1  one-cycle pulse per captured gate
- resGate  out  GSEL_W  gate index qualified by resValid
- resData  out  MEMORY_BITWIDTH  captured vector qualified by resValid
- gateBus  out  NGATES*MEMORY_BITWIDTH  all result banks; gate g occupies [g*MEMORY_BITWIDTH +: MEMORY_BITWIDTH]

Behaviour:
- Reset values: dpReset=1; every other output, every bank, every counter and the edge register = 0; state IDLE.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - dpReset=1, busy=0.
  - start=1 -> CLEAR next cycle, with gateSel=0, busy=1, error cleared.
- CLEAR:
  - dpReset=1; the counter runs CLR_CYCLES cycles, then -> RUN.
  - The watchdog is zeroed on entry.
- RUN:
  - dpReset=0.
  - Edge register loads dpDataReady every cycle in every state. A rise is dpDataReady & ~edgeReg. A level that is already high on RUN entry is not a rise, because the edge register was sampled during CLEAR.
  - On a rise: bank[gateSel] <= dpOutputVec; the next cycle gives resValid=1, resGate=gateSel, resData=dpOutputVec (registered).
  - After a rise: if gateSel == NGATES-1 -> DONE; otherwise gateSel+1 -> CLEAR.
  - The watchdog increments each RUN cycle. If it reaches TIMEOUT-1 with no rise -> IDLE, error=1, busy=0, no done.
- DONE: done=1 for one cycle, busy drops the same cycle, dpReset=1 -> IDLE.
- Latency: from the start cycle, dpReset falls after 1+CLR_CYCLES clocks. Capture happens on the rise cycle; resValid follows 1 cycle later.
- abort=1 in any non-IDLE state:
  - -> IDLE next cycle, dpReset=1, busy=0.
  - No done and no resValid that cycle, even if a rise coincides. Abort has priority.
  - Banks keep earlier captures.
- start while busy is ignored. start and abort together in IDLE: start is accepted, abort is ignored.
- reset mid-run: immediate return to reset values, including the banks.
- gateSel does not wrap within a run; it resets to 0 only on start acceptance.
- Data is not interpreted. No arithmetic is done on the vectors; widths pass through unchanged.

Decomposition:
- Shared package (rnn_pkg): state encoding; gate index constants GATE_I=0, GATE_F=1, GATE_O=2, GATE_C=3; BITWIDTH/MEMORY_BITWIDTH derivation; clog2 function.
- One sub-module, sched_watchdog: rising-edge detector plus TIMEOUT counter, with inputs clear/enable/level and outputs rise/expired.

Test Plan:
- Nominal run (NGATES=4, CLR_CYCLES=2): dot_prod model raises dataReady 12 cycles after dpReset falls, returning vector value 0x100*(g+1) per element. Required: first dpReset fall 3 cycles after start; exactly 4 resValid pulses with resGate 0,1,2,3; gateBus slices match; done pulses once; busy deasserts in the done cycle.
- Stale dataReady: model holds dataReady high through CLEAR into RUN, then drops and re-raises it after 5 cycles. Required: no capture on RUN entry; capture only at the re-rise.
- Timeout (TIMEOUT=16): model never asserts dataReady for gate 2. Required: error=1 and busy=0 after 16 RUN cycles; no done; bank 2 unchanged; next start clears error.
- Abort coincident with the rise on gate 1: required no resValid that cycle, bank 1 unchanged, IDLE next cycle, dpReset=1.
- start pulsed while busy, then reset asserted mid-RUN of gate 3: required second start ignored (single run); after reset gateBus=0, dpReset=1, gateSel=0.
- NGATES=1 build: one capture, then done; gateSel stays 0 throughout.

Source files
------------

// File: rtl/rnn_pkg.sv
// Shared definitions for the LSTM gate scheduler slice.
//   - sched_state_t : scheduler FSM state encoding
//   - GATE_*        : gate index constants in run order (i, f, o, c)
//   - clog2 / width helpers used to derive port widths from the Q format
package rnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

  localparam int GATE_I = 0;
  localparam int GATE_F = 1;
  localparam int GATE_O = 2;
  localparam int GATE_C = 3;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int p = 1; p < value; p = p * 2) begin
      result++;
    end
    return result;
  endfunction

  // One fixed-point element: sign + QN integer + QM fractional bits.
  function automatic int bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  // One full outputVec word from dot_prod.
  function automatic int mem_bitwidth(input int qn, input int qm, input int nrow);
    return bitwidth(qn, qm) * nrow;
  endfunction

  // Gate select width never collapses to zero, even for a single gate.
  function automatic int gsel_width(input int ngates);
    return (clog2(ngates) < 1) ? 1 : clog2(ngates);
  endfunction

endpackage

// File: rtl/sched_watchdog.sv
// Rising-edge detector and RUN watchdog for the gate scheduler.
//   clock   : system clock
//   reset   : synchronous active-high reset
//   clear   : zero the watchdog counter
//   enable  : count this cycle (scheduler is in RUN)
//   level   : raw dataReady level from dot_prod
//   rise    : level high now and low in the previous cycle
//   expired : counter has reached TIMEOUT-1 while enabled
module sched_watchdog
  import rnn_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic level,
  output logic rise,
  output logic expired
);

  localparam int CNT_W = clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic             edge_reg;
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      edge_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      // Sampled in every state, so a level already high when RUN begins
      // is seen as old and does not count as a rise.
      edge_reg <= level;
      if (clear) begin
        count_reg <= '0;
      end else if (enable && (count_reg != LIMIT)) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign rise    = level & ~edge_reg;
  assign expired = enable & (count_reg == LIMIT);

endmodule

// File: rtl/lstm_gate_sched.sv
// Sequencer sharing one dot_prod/weightRAM pair across NGATES LSTM gates.
// Each gate: hold dpReset for CLR_CYCLES, release it, wait for a dataReady
// rising edge and capture outputVec into that gate's result bank.
//   clock, reset        : clock, synchronous active-high reset
//   start, abort        : run request (IDLE only) / cancel run
//   dpDataReady         : dataReady from dot_prod
//   dpOutputVec         : outputVec from dot_prod
//   dpReset             : restart for dot_prod and weightRAM
//   gateSel             : weight bank of the gate being run
//   busy, done, error   : run status, done pulse, sticky watchdog flag
//   resValid/resGate/resData : one pulse per captured gate
//   gateBus             : all result banks, gate g at [g*MEMORY_BITWIDTH +:]
module lstm_gate_sched
  import rnn_pkg::*;
#(
  parameter int NROW       = 16,
  parameter int NCOL       = 8,
  parameter int QN         = 6,
  parameter int QM         = 11,
  parameter int NGATES     = 4,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 256,
  localparam int BITWIDTH        = bitwidth(QN, QM),
  localparam int MEMORY_BITWIDTH = mem_bitwidth(QN, QM, NROW),
  localparam int GSEL_W          = gsel_width(NGATES)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              dpDataReady,
  input  logic [MEMORY_BITWIDTH-1:0]        dpOutputVec,
  output logic                              dpReset,
  output logic [GSEL_W-1:0]                 gateSel,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic                              resValid,
  output logic [GSEL_W-1:0]                 resGate,
  output logic [MEMORY_BITWIDTH-1:0]        resData,
  output logic [NGATES*MEMORY_BITWIDTH-1:0] gateBus
);

  localparam int CLR_W = clog2(CLR_CYCLES) + 1;
  localparam logic [CLR_W-1:0]  LAST_CLR  = CLR_W'(CLR_CYCLES - 1);
  localparam logic [GSEL_W-1:0] LAST_GATE = GSEL_W'(NGATES - 1);

  // NCOL only shapes the dot_prod side; nothing here depends on it.
  if (NCOL < 1 || BITWIDTH < 1) begin : g_degenerate_shape
  end

  sched_state_t               state_reg;
  logic [CLR_W-1:0]           clr_cnt_reg;
  logic [MEMORY_BITWIDTH-1:0] bank_reg [NGATES];
  logic                       rise;
  logic                       expired;
  logic                       capture;

  sched_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_reg == S_CLEAR),
    .enable  (state_reg == S_RUN),
    .level   (dpDataReady),
    .rise    (rise),
    .expired (expired)
  );

  // Abort outranks a coincident rise: nothing is captured that cycle.
  assign capture = (state_reg == S_RUN) && !abort && rise;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      clr_cnt_reg <= '0;
      dpReset     <= 1'b1;
      gateSel     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      resValid    <= 1'b0;
      resGate     <= '0;
      resData     <= '0;
    end else begin
      done     <= 1'b0;
      resValid <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          dpReset <= 1'b1;
          busy    <= 1'b0;
          if (start) begin
            state_reg   <= S_CLEAR;
            clr_cnt_reg <= '0;
            gateSel     <= '0;
            busy        <= 1'b1;
            error       <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (abort) begin
            state_reg <= S_IDLE;
            dpReset   <= 1'b1;
            busy      <= 1'b0;
          end else if (clr_cnt_reg == LAST_CLR) begin
            state_reg <= S_RUN;
            dpReset   <= 1'b0;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_reg <= S_IDLE;
            dpReset   <= 1'b1;
            busy      <= 1'b0;
          end else if (rise) begin
            resValid <= 1'b1;
            resGate  <= gateSel;
            resData  <= dpOutputVec;
            dpReset  <= 1'b1;
            if (gateSel == LAST_GATE) begin
              // done and the busy drop land in the same cycle.
              state_reg <= S_DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state_reg   <= S_CLEAR;
              clr_cnt_reg <= '0;
              gateSel     <= gateSel + 1'b1;
            end
          end else if (expired) begin
            state_reg <= S_IDLE;
            dpReset   <= 1'b1;
            busy      <= 1'b0;
            error     <= 1'b1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          dpReset   <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          dpReset   <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // One bank per gate; banks survive abort and watchdog expiry.
  for (genvar gi = 0; gi < NGATES; gi++) begin : g_bank
    always_ff @(posedge clock) begin
      if (reset) begin
        bank_reg[gi] <= '0;
      end else if (capture && (gateSel == GSEL_W'(gi))) begin
        bank_reg[gi] <= dpOutputVec;
      end
    end
    assign gateBus[gi*MEMORY_BITWIDTH +: MEMORY_BITWIDTH] = bank_reg[gi];
  end

endmodule

// File: tb/tb_lstm_gate_sched.sv
module tb_lstm_gate_sched;

  localparam int NROW = 16;
  localparam int NCOL = 8;
  localparam int QN   = 6;
  localparam int QM   = 11;
  localparam int NG   = 4;
  localparam int CLR  = 2;
  localparam int TMO  = 16;
  localparam int BW   = QN + QM + 1;
  localparam int MB   = BW * NROW;

  localparam int M_NORM  = 0;
  localparam int M_STALE = 1;
  localparam int M_NEVER = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           dpDataReady = 1'b0;
  logic [MB-1:0]  dpOutputVec = '0;
  logic           dpReset;
  logic [1:0]     gateSel;
  logic           busy, done, error, resValid;
  logic [1:0]     resGate;
  logic [MB-1:0]  resData;
  logic [NG*MB-1:0] gateBus;

  // Single-gate build
  logic           start1 = 1'b0;
  logic           abort1 = 1'b0;
  logic           dr1 = 1'b0;
  logic [MB-1:0]  vec1 = '0;
  logic           dpReset1;
  logic [0:0]     gateSel1;
  logic           busy1, done1, error1, resValid1;
  logic [0:0]     resGate1;
  logic [MB-1:0]  resData1;
  logic [MB-1:0]  gateBus1;

  always #5 clock = ~clock;

  lstm_gate_sched #(
    .NROW(NROW), .NCOL(NCOL), .QN(QN), .QM(QM),
    .NGATES(NG), .CLR_CYCLES(CLR), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .dpDataReady(dpDataReady), .dpOutputVec(dpOutputVec),
    .dpReset(dpReset), .gateSel(gateSel), .busy(busy), .done(done),
    .error(error), .resValid(resValid), .resGate(resGate),
    .resData(resData), .gateBus(gateBus)
  );

  lstm_gate_sched #(
    .NROW(NROW), .NCOL(NCOL), .QN(QN), .QM(QM),
    .NGATES(1), .CLR_CYCLES(CLR), .TIMEOUT(TMO)
  ) dut1 (
    .clock(clock), .reset(reset), .start(start1), .abort(abort1),
    .dpDataReady(dr1), .dpOutputVec(vec1),
    .dpReset(dpReset1), .gateSel(gateSel1), .busy(busy1), .done(done1),
    .error(error1), .resValid(resValid1), .resGate(resGate1),
    .resData(resData1), .gateBus(gateBus1)
  );

  typedef struct {
    int            g;
    logic [MB-1:0] d;
  } exp_t;

  exp_t          exp_q[$];
  logic [MB-1:0] exp_bank [NG];
  int            vectors = 0;
  int            miscompares = 0;

  task automatic check(input string name, input logic [MB-1:0] act, input logic [MB-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [MB-1:0] rep(input logic [BW-1:0] w);
    return {NROW{w}};
  endfunction

  function automatic logic [MB-1:0] rand_vec();
    logic [MB-1:0] v;
    for (int e = 0; e < NROW; e++) v[e*BW +: BW] = BW'($urandom);
    return v;
  endfunction

  // ---------------- dot_prod behavioural model ----------------
  int            cyc = 0;
  int            run_cnt = 0;
  int            mode [NG];
  int            dly [NG];
  logic [MB-1:0] vec [NG];
  int            max_run [NG];
  int            abort_gate = -1;
  int            abort_cyc = -1;
  logic [MB-1:0] bad_vec = {NROW{18'h2BAD5}};

  always begin
    @(posedge clock);
    cyc++;
    #1;
    abort = 1'b0;
    if (reset || dpReset) begin
      run_cnt = 0;
    end else begin
      run_cnt++;
      if (run_cnt > max_run[int'(gateSel)]) max_run[int'(gateSel)] = run_cnt;
    end
    case (mode[int'(gateSel)])
      M_STALE: begin
        dpDataReady = busy && (dpReset || run_cnt <= 2 || run_cnt > 7);
        dpOutputVec = (dpReset || run_cnt <= 2) ? bad_vec : vec[int'(gateSel)];
      end
      M_NEVER: begin
        dpDataReady = 1'b0;
        dpOutputVec = bad_vec;
      end
      default: begin
        dpDataReady = !dpReset && (run_cnt > dly[int'(gateSel)]);
        dpOutputVec = dpDataReady ? vec[int'(gateSel)] : bad_vec;
      end
    endcase
    if (int'(gateSel) == abort_gate && !dpReset && run_cnt == dly[int'(gateSel)] + 1) begin
      abort     = 1'b1;
      abort_cyc = cyc;
    end
  end

  // Single-gate model: ready 6 cycles after dpReset falls.
  int cnt1 = 0;
  always begin
    @(posedge clock);
    #1;
    if (reset || dpReset1) cnt1 = 0; else cnt1++;
    dr1 = !dpReset1 && (cnt1 > 5);
  end

  // ---------------- monitor / scoreboard ----------------
  int   done_cnt = 0;
  int   fall_cyc = -1;
  logic fall_dpr = 1'b0;
  int   first_fall_cyc = -1;
  logic busy_q = 1'b0;
  logic dpr_q = 1'b1;
  int   res1_cnt = 0;
  int   done1_cnt = 0;
  int   gsel1_nz = 0;

  always @(negedge clock) begin
    if (reset) begin
      busy_q = 1'b0;
      dpr_q  = 1'b1;
    end else begin
      if (resValid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_res: got gate %0d data %0h expected no result", resGate, resData);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("res gate=%0d data=%0h", resGate, resData[63:0]);
          check_int("resGate", int'(resGate), e.g);
          check("resData", resData, e.d);
          check($sformatf("gateBus_slice%0d", e.g), gateBus[e.g*MB +: MB], e.d);
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_in_done", MB'(busy), '0);
      end
      if (busy_q && !busy) begin
        fall_cyc = cyc;
        fall_dpr = dpReset;
      end
      if (dpr_q && !dpReset && first_fall_cyc < 0) first_fall_cyc = cyc;
      busy_q = busy;
      dpr_q  = dpReset;
      if (resValid1) begin
        res1_cnt++;
        check_int("ng1_resGate", int'(resGate1), 0);
        check("ng1_resData", resData1, vec1);
      end
      if (done1) done1_cnt++;
      if (gateSel1 != 1'b0) gsel1_nz++;
    end
  end

  // ---------------- stimulus ----------------
  int start_cyc = 0;

  task automatic check_banks(input string tag);
    for (int g = 0; g < NG; g++)
      check($sformatf("%s_bank%0d", tag, g), gateBus[g*MB +: MB], exp_bank[g]);
  endtask

  task automatic set_plan(input bit nominal);
    for (int g = 0; g < NG; g++) begin
      mode[g]    = M_NORM;
      max_run[g] = 0;
      dly[g]     = nominal ? 12 : int'($urandom_range(1, 13));
      vec[g]     = nominal ? rep(BW'(16'h100 * (g + 1))) : rand_vec();
    end
  endtask

  // Runs one start; ncap gates are expected to be captured in order.
  task automatic do_run(input string tag, input int ncap, input int restart_at);
    bit finished;
    done_cnt       = 0;
    fall_cyc       = -1;
    first_fall_cyc = -1;
    for (int g = 0; g < ncap; g++) begin
      exp_t e;
      e.g = g;
      e.d = vec[g];
      exp_q.push_back(e);
      exp_bank[g] = vec[g];
    end
    @(posedge clock); #2;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clock); #2;
    start = 1'b0;
    check({tag, "_error_cleared"}, MB'(error), '0);
    check({tag, "_busy_on_start"}, MB'(busy), MB'(1));
    finished = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock); #2;
      start = (i == restart_at);
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_run_finished"}, MB'(finished), MB'(1));
    repeat (3) @(negedge clock);
    check_int({tag, "_results_left"}, exp_q.size(), 0);
    exp_q.delete();
    $display("run %s: captures=%0d done=%0d error=%0b", tag, ncap, done_cnt, error);
  endtask

  initial begin
    for (int g = 0; g < NG; g++) exp_bank[g] = '0;
    set_plan(1'b1);
    repeat (3) @(posedge clock);
    #2;
    check("rst_dpReset", MB'(dpReset), MB'(1));
    check("rst_busy", MB'(busy), '0);
    check("rst_done", MB'(done), '0);
    check("rst_error", MB'(error), '0);
    check("rst_resValid", MB'(resValid), '0);
    check("rst_gateSel", MB'(gateSel), '0);
    check_banks("rst");
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // Nominal
    set_plan(1'b1);
    do_run("nominal", NG, -1);
    check_int("nominal_dpReset_fall_latency", first_fall_cyc - start_cyc, 1 + CLR);
    check_int("nominal_done_count", done_cnt, 1);
    check("nominal_error", MB'(error), '0);
    check_banks("nominal");

    // Stale dataReady on gate 1
    set_plan(1'b0);
    mode[1] = M_STALE;
    do_run("stale", NG, -1);
    check_int("stale_done_count", done_cnt, 1);
    check_banks("stale");

    // Watchdog on gate 2
    set_plan(1'b0);
    mode[2] = M_NEVER;
    do_run("timeout", 2, -1);
    check("timeout_error", MB'(error), MB'(1));
    check("timeout_busy", MB'(busy), '0);
    check_int("timeout_done_count", done_cnt, 0);
    check_int("timeout_run_cycles", max_run[2], TMO);
    check_banks("timeout");

    // Abort coincident with the rise on gate 1
    set_plan(1'b0);
    abort_gate = 1;
    do_run("abort", 1, -1);
    abort_gate = -1;
    check_int("abort_idle_next_cycle", fall_cyc - abort_cyc, 1);
    check("abort_dpReset", MB'(fall_dpr), MB'(1));
    check_int("abort_done_count", done_cnt, 0);
    check("abort_error", MB'(error), '0);
    check_banks("abort");

    // start pulsed while busy
    set_plan(1'b0);
    do_run("busy_start", NG, 20);
    check_int("busy_start_done_count", done_cnt, 1);
    repeat (10) @(posedge clock);
    #2;
    check("busy_start_idle_after", MB'(busy), '0);
    check_banks("busy_start");

    // A few random runs
    for (int r = 0; r < 3; r++) begin
      set_plan(1'b0);
      do_run($sformatf("rand%0d", r), NG, -1);
      check_int($sformatf("rand%0d_done_count", r), done_cnt, 1);
      check_banks($sformatf("rand%0d", r));
    end

    // Reset during RUN of gate 3
    begin
      bit reached;
      set_plan(1'b0);
      dly[3] = 12;
      for (int g = 0; g < NG - 1; g++) begin
        exp_t e;
        e.g = g;
        e.d = vec[g];
        exp_q.push_back(e);
      end
      @(posedge clock); #2;
      start = 1'b1;
      @(posedge clock); #2;
      start = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(posedge clock); #2;
        if (gateSel == 2'd3 && !dpReset) begin
          reached = 1'b1;
          break;
        end
      end
      check("midreset_reached_gate3", MB'(reached), MB'(1));
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b1;
      @(posedge clock); #2;
      for (int g = 0; g < NG; g++) exp_bank[g] = '0;
      check_banks("midreset");
      check("midreset_dpReset", MB'(dpReset), MB'(1));
      check("midreset_gateSel", MB'(gateSel), '0);
      check("midreset_busy", MB'(busy), '0);
      check_int("midreset_results_left", exp_q.size(), 0);
      exp_q.delete();
      reset = 1'b0;
      $display("run midreset: reset applied during gate 3");
    end

    // Single-gate build
    begin
      bit fin1;
      res1_cnt  = 0;
      done1_cnt = 0;
      gsel1_nz  = 0;
      vec1      = rand_vec();
      @(posedge clock); #2;
      start1 = 1'b1;
      @(posedge clock); #2;
      start1 = 1'b0;
      fin1 = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(posedge clock); #2;
        if (!busy1) begin
          fin1 = 1'b1;
          break;
        end
      end
      repeat (3) @(negedge clock);
      check("ng1_finished", MB'(fin1), MB'(1));
      check_int("ng1_captures", res1_cnt, 1);
      check_int("ng1_done_count", done1_cnt, 1);
      check_int("ng1_gateSel_nonzero_cycles", gsel1_nz, 0);
      check("ng1_bank", gateBus1, vec1);
      check("ng1_error", MB'(error1), '0);
      $display("run ng1: captures=%0d done=%0d", res1_cnt, done1_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
